// File: rtl/mips_driver.sv
`default_nettype none
// ============================================================================
// Module      : mips_driver
// Description : Encodes MIPS requests into a FIFO and issues them to a core,
//               tracking in-flight work and saturating core fail count.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_rs,
    input  logic [2:0]  req_rt,
    input  logic [2:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [15:0] req_imm,
    input  logic        hold,
    output logic        in_valid,
    output logic [31:0] instruction,
    input  logic        out_valid,
    input  logic        instruction_fail,
    output logic        idle,
    output logic        done,
    output logic [7:0]  fail_cnt
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [4:0] map_reg(input logic [2:0] idx);
        logic [4:0] r;
        case (idx)
            3'd0:    r = 5'b10001;
            3'd1:    r = 5'b10010;
            3'd2:    r = 5'b01000;
            3'd3:    r = 5'b10111;
            3'd4:    r = 5'b11111;
            3'd5:    r = 5'b10000;
            default: r = 5'b00000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] encode(
        input logic [2:0]  op,
        input logic [2:0]  rs,
        input logic [2:0]  rt,
        input logic [2:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {6'b000000, map_reg(rs), map_reg(rt), map_reg(rd), shamt, 6'b100000};
            3'd1:    w = {6'b000000, map_reg(rs), map_reg(rt), map_reg(rd), 5'd0,  6'b100100};
            3'd2:    w = {6'b000000, map_reg(rs), map_reg(rt), map_reg(rd), 5'd0,  6'b100101};
            3'd3:    w = {6'b000000, map_reg(rs), map_reg(rt), map_reg(rd), 5'd0,  6'b100111};
            3'd4:    w = {6'b000000, 5'd0,        map_reg(rt), map_reg(rd), shamt, 6'b000000};
            3'd5:    w = {6'b000000, 5'd0,        map_reg(rt), map_reg(rd), shamt, 6'b000010};
            // ADDI targets map(rd) in the rt slot
            3'd6:    w = {6'b001000, map_reg(rs), map_reg(rd), imm};
            default: w = 32'h8000_0000;
        endcase
        return w;
    endfunction

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [2:0]    inflight_q;
    logic [7:0]    fail_cnt_q;
    logic [31:0]   instruction_q;
    logic          in_valid_q;
    logic          done_q;
    state_e        state_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = req_valid && !full;
    assign pop   = (state_q == ISSUE) && !hold && !empty;

    assign req_ready   = !full;
    assign in_valid    = in_valid_q;
    assign instruction = instruction_q;
    assign idle        = (state_q == IDLE);
    assign done        = done_q;
    assign fail_cnt    = fail_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= encode(req_op, req_rs, req_rt, req_rd, req_shamt, req_imm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= '0;
            fail_cnt_q    <= '0;
            instruction_q <= '0;
            in_valid_q    <= 1'b0;
            done_q        <= 1'b0;
            state_q       <= IDLE;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase

            in_valid_q    <= pop;
            instruction_q <= pop ? mem_q[rd_ptr_q] : 32'd0;

            case ({in_valid_q, out_valid})
                2'b10: inflight_q <= inflight_q + 1'b1;
                2'b01: if (inflight_q != 3'd0) inflight_q <= inflight_q - 1'b1;
                default: ;
            endcase

            if (out_valid && instruction_fail && (fail_cnt_q != 8'hFF)) begin
                fail_cnt_q <= fail_cnt_q + 1'b1;
            end

            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) state_q <= ISSUE;
                end
                ISSUE: begin
                    if (empty) state_q <= DRAIN;
                end
                DRAIN: begin
                    // New work takes priority over finishing the batch
                    if (!empty) begin
                        state_q <= ISSUE;
                    end else if ((inflight_q == 3'd0) && !in_valid_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_driver
// Description : Directed self-checking bench for mips_driver with a reference
//               encoder, FIFO-order scoreboard and 2-cycle core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [2:0]  req_rs = '0;
    logic [2:0]  req_rt = '0;
    logic [2:0]  req_rd = '0;
    logic [4:0]  req_shamt = '0;
    logic [15:0] req_imm = '0;
    logic        hold = 1'b0;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid = 1'b0;
    logic        instruction_fail = 1'b0;
    logic        idle;
    logic        done;
    logic [7:0]  fail_cnt;

    always #5 clk = ~clk;

    mips_driver #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_rs           (req_rs),
        .req_rt           (req_rt),
        .req_rd           (req_rd),
        .req_shamt        (req_shamt),
        .req_imm          (req_imm),
        .hold             (hold),
        .in_valid         (in_valid),
        .instruction      (instruction),
        .out_valid        (out_valid),
        .instruction_fail (instruction_fail),
        .idle             (idle),
        .done             (done),
        .fail_cnt         (fail_cnt)
    );

    localparam logic [4:0] MAP   [8] = '{5'b10001, 5'b10010, 5'b01000, 5'b10111,
                                         5'b11111, 5'b10000, 5'b00000, 5'b00000};
    localparam logic [5:0] FUNCT [6] = '{6'b100000, 6'b100100, 6'b100101,
                                         6'b100111, 6'b000000, 6'b000010};

    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          run = 0;
    int          max_run = 0;
    int          model_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] issued [$];
    logic        hv0 = 1'b0, hv1 = 1'b0;
    logic [31:0] hw0 = '0, hw1 = '0;
    logic        done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_enc(input logic [2:0] op, input logic [2:0] rs,
                                              input logic [2:0] rt, input logic [2:0] rd,
                                              input logic [4:0] sh, input logic [15:0] imm);
        logic [4:0] rsf;
        logic [4:0] shf;
        if (op == 3'd7) return 32'h8000_0000;
        if (op == 3'd6) return {6'b001000, MAP[rs], MAP[rd], imm};
        rsf = (op == 3'd4 || op == 3'd5) ? 5'd0 : MAP[rs];
        shf = (op >= 3'd1 && op <= 3'd3) ? 5'd0 : sh;
        return {6'b000000, rsf, MAP[rt], MAP[rd], shf, FUNCT[op]};
    endfunction

    // Output checker plus core responder (out_valid two cycles after in_valid)
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hv0 = 1'b0; hv1 = 1'b0; out_valid = 1'b0; instruction_fail = 1'b0;
                run = 0; done_prev = 1'b0;
            end else begin
                if (in_valid) begin
                    issued.push_back(instruction);
                    run++;
                    if (run > max_run) max_run = run;
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_issue: got in_valid=1 word 0x%08h, required no issue", instruction);
                    end else begin
                        check("issue_word", instruction, exp_q.pop_front());
                    end
                end else begin
                    run = 0;
                    check("word_zero_when_invalid", instruction, 32'd0);
                end
                check("fail_cnt", {24'd0, fail_cnt}, model_fail);
                if (done) begin
                    done_cnt++;
                    check("done_one_cycle", {31'd0, done_prev}, 32'd0);
                    check("done_with_idle", {31'd0, idle}, 32'd1);
                end
                done_prev = done;
                out_valid = hv1;
                instruction_fail = hv1 && (hw1 == 32'h8000_0000);
                if (out_valid && instruction_fail && model_fail < 255) model_fail++;
                hv1 = hv0; hw1 = hw0;
                hv0 = in_valid; hw0 = instruction;
            end
        end
    end

    task automatic push(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        logic acc;
        req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm;
        req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            acc = req_ready;
            @(negedge clk);
            if (acc) begin
                exp_q.push_back(model_enc(op, rs, rt, rd, sh, imm));
                req_valid = 1'b0;
                return;
            end
        end
        tests++; fails++;
        $display("FAIL push_timeout: got req_ready=0 for 200 cycles, required acceptance");
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) return;
        end
        tests++; fails++;
        $display("FAIL idle_timeout: got idle=%0b queued=%0d, required idle with nothing queued", idle, exp_q.size());
    endtask

    int d0;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_in_valid", {31'd0, in_valid}, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fail_cnt", {24'd0, fail_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD single issue
        d0 = done_cnt; max_run = 0; issued.delete();
        push(3'd0, 3'd0, 3'd1, 3'd2, 5'd0, 16'd0);
        wait_idle(); @(negedge clk);
        check("add_word", issued[0], 32'h0232_4020);
        check("add_issue_count", issued.size(), 32'd1);
        check("add_one_cycle_valid", max_run, 32'd1);
        check("add_done_pulses", done_cnt - d0, 32'd1);

        // ADDI and SLL (SLL given nonzero rs to confirm it is forced to 0)
        issued.delete();
        push(3'd6, 3'd5, 3'd0, 3'd3, 5'd0, 16'h1234);
        push(3'd4, 3'd2, 3'd4, 3'd0, 5'd3, 16'h0);
        wait_idle(); @(negedge clk);
        check("addi_word", issued[0], 32'h2217_1234);
        check("sll_word", issued[1], 32'h001F_88C0);

        // ILLEGAL with core fail
        d0 = done_cnt; issued.delete();
        push(3'd7, 3'd1, 3'd2, 3'd3, 5'd4, 16'h5555);
        wait_idle(); @(negedge clk);
        check("illegal_word", issued[0], 32'h8000_0000);
        check("illegal_fail_cnt", {24'd0, fail_cnt}, 32'd1);
        check("illegal_done_pulses", done_cnt - d0, 32'd1);

        // Logical ops drop shamt, SRL drops rs
        issued.delete();
        push(3'd1, 3'd3, 3'd4, 3'd5, 5'd7, 16'h0);
        push(3'd2, 3'd6, 3'd7, 3'd0, 5'd9, 16'h0);
        push(3'd3, 3'd1, 3'd2, 3'd3, 5'd1, 16'h0);
        push(3'd5, 3'd1, 3'd0, 3'd1, 5'd31, 16'h0);
        wait_idle(); @(negedge clk);
        check("and_word", issued[0], 32'h02FF_8024);
        check("srl_word", issued[3], 32'h0011_97C2);

        // Fill under hold, then release with a fifth request pending
        d0 = done_cnt; issued.delete();
        hold = 1'b1;
        push(3'd0, 3'd1, 3'd2, 3'd3, 5'd1, 16'h0);
        push(3'd1, 3'd2, 3'd3, 3'd4, 5'd0, 16'h0);
        push(3'd6, 3'd3, 3'd0, 3'd5, 5'd0, 16'hBEEF);
        push(3'd5, 3'd0, 3'd5, 3'd0, 5'd2, 16'h0);
        check("full_ready_low", {31'd0, req_ready}, 32'd0);
        check("full_not_idle", {31'd0, idle}, 32'd0);
        repeat (3) @(negedge clk);
        check("hold_no_issue", issued.size(), 32'd0);
        hold = 1'b0; max_run = 0;
        push(3'd2, 3'd4, 3'd1, 3'd2, 5'd0, 16'h0);
        wait_idle(); @(negedge clk);
        check("hold_total_issues", issued.size(), 32'd5);
        check("hold_back_to_back", {31'd0, (max_run >= 4)}, 32'd1);
        check("hold_done_pulses", done_cnt - d0, 32'd1);

        // Fail counter saturation
        for (int i = 0; i < 256; i++) push(3'd7, 3'd0, 3'd0, 3'd0, 5'd0, 16'h0);
        wait_idle(); @(negedge clk);
        check("fail_cnt_saturated", {24'd0, fail_cnt}, 32'd255);
        push(3'd7, 3'd0, 3'd0, 3'd0, 5'd0, 16'h0);
        wait_idle(); @(negedge clk);
        check("fail_cnt_stays", {24'd0, fail_cnt}, 32'd255);

        // Reset with 3 queued and 2 issued but unanswered
        hold = 1'b1; issued.delete();
        push(3'd0, 3'd0, 3'd1, 3'd2, 5'd0, 16'h0);
        push(3'd0, 3'd1, 3'd2, 3'd3, 5'd0, 16'h0);
        push(3'd0, 3'd2, 3'd3, 3'd4, 5'd0, 16'h0);
        push(3'd0, 3'd3, 3'd4, 3'd5, 5'd0, 16'h0);
        hold = 1'b0;
        push(3'd0, 3'd4, 3'd5, 3'd0, 5'd0, 16'h0);
        hold = 1'b1;
        check("pre_reset_issued", issued.size(), 32'd2);
        #1 rst_n = 1'b0;
        exp_q.delete(); model_fail = 0; d0 = done_cnt;
        #1;
        check("mid_rst_in_valid", {31'd0, in_valid}, 32'd0);
        check("mid_rst_instruction", instruction, 32'd0);
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; hold = 1'b0; issued.delete();
        repeat (20) @(negedge clk);
        check("post_rst_no_issue", issued.size(), 32'd0);
        check("post_rst_no_done", done_cnt - d0, 32'd0);
        check("post_rst_idle", {31'd0, idle}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_driver.md
MIPS_DRIVER -- requirements
Module: mips_driver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the request FIFO depth in entries (power of two, at least 2).
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request offered
- req_ready  output  1  request accepted when high together with req_valid
- req_op  input  3  operation: 0 ADD, 1 AND, 2 OR, 3 NOR, 4 SLL, 5 SRL, 6 ADDI, 7 ILLEGAL
- req_rs, req_rt, req_rd  input  3 each  logical register index
- req_shamt  input  5  shift amount
- req_imm  input  16  ADDI immediate
- hold  input  1  pause issue
- in_valid  output  1  instruction valid to the core
- instruction  output  32  encoded instruction to the core
- out_valid  input  1  core response valid
- instruction_fail  input  1  core fail flag
- idle  output  1  FSM in IDLE
- done  output  1  one-cycle pulse when a batch completes
- fail_cnt  output  8  saturating count of core fails
REQ-003 Reset rst_n SHALL be asynchronous and active-low; the clock SHALL be clk.

Function
REQ-004 Register map SHALL be: index 0->5'b10001, 1->10010, 2->01000, 3->10111, 4->11111, 5->10000; index 6 or 7 -> 5'b00000.
REQ-005 R-type encoding SHALL be opcode 6'b000000, rs, rt, rd, shamt, funct.
REQ-006 Funct codes SHALL be: ADD 100000, AND 100100, OR 100101, NOR 100111, SLL 000000, SRL 000010.
REQ-007 For AND, OR and NOR, shamt SHALL be 0. For SLL and SRL, the rs field SHALL be 0.
REQ-008 ADDI SHALL encode as opcode 001000, rs, rt=map(req_rd), imm.
REQ-009 ILLEGAL SHALL encode as 32'h80000000.
REQ-010 Requests SHALL be encoded on push and stored in a DEPTH-entry FIFO.
REQ-011 req_ready SHALL equal !full; a push SHALL occur when req_valid && req_ready.
REQ-012 Simultaneous push and pop SHALL be allowed when the FIFO is not full; the count SHALL be unchanged.
REQ-013 FSM states SHALL be IDLE, ISSUE and DRAIN.
- IDLE->ISSUE when the FIFO is non-empty.
- ISSUE->DRAIN when the FIFO is empty.
- DRAIN->ISSUE when the FIFO is non-empty; this has priority.
- DRAIN->IDLE when inflight==0 and in_valid==0.
REQ-014 A pop SHALL occur in ISSUE when !hold && !empty; the next cycle SHALL show in_valid=1 and instruction=popped word.
REQ-015 Issue rate SHALL be at most one instruction per cycle, back-to-back allowed.
REQ-016 instruction SHALL be 0 whenever in_valid=0.
REQ-017 hold SHALL stop pops on the cycle it is sampled high and SHALL NOT drop FIFO contents.
REQ-018 Core response latency is 2 cycles after in_valid.
REQ-019 A 3-bit inflight counter SHALL count +1 on in_valid and -1 on out_valid; simultaneous events SHALL leave it unchanged.
REQ-020 fail_cnt SHALL increment on out_valid && instruction_fail and saturate at 255.
REQ-021 done SHALL pulse for exactly one cycle on the DRAIN->IDLE transition.
REQ-022 idle SHALL be 1 only in IDLE.

Reset
REQ-023 On rst_n low, all outputs SHALL be driven immediately to reset values: req_ready=1, in_valid=0, instruction=0, idle=1, done=0, fail_cnt=0.
REQ-024 On rst_n low, the FIFO SHALL empty, inflight SHALL be 0 and the FSM SHALL go to IDLE.
REQ-025 Reset mid-batch SHALL discard queued requests without any further in_valid.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- ADD rs=0 rt=1 rd=2 -> instruction=0x02324020 one cycle after pop, in_valid=1 for one cycle.
- ADDI rs=5 rd=3 imm=0x1234 -> 0x22171234; SLL rt=4 rd=0 shamt=3 -> 0x001F88C0.
- ILLEGAL then core returns out_valid+instruction_fail -> 0x80000000 issued, fail_cnt=1, done pulses once inflight reaches 0.
- Push 5 requests with DEPTH=4 and hold=1 -> req_ready=0 after 4; release hold -> 4 back-to-back in_valid, 5th accepted, 5 issues total in push order.
- fail_cnt at 255 plus another fail -> stays 255.
- rst_n asserted with 3 queued and 2 inflight -> in_valid=0 immediately, idle=1, no done pulse, no issues after release.
